// File: rtl/instr_loader.sv
// Boot-stream loader: parses sync/count/words frames and writes instruction memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        DONE
    } state_t;

    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [31:0] BASE_U  = 32'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL = CHK;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic [15:0] len_n;

    assign byte_ready = (state_q != DONE);
    assign accept     = byte_valid && byte_ready;
    assign len_n      = {len_q[15:8], byte_in};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (byte_in == SYNC) begin
                        state_d = LEN_HI;
                    end
                end
                LEN_HI: begin
                    len_d   = {byte_in, len_q[7:0]};
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d  = len_n;
                    idx_d  = 16'd0;
                    bcnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = 8'd0;
`endif
                    if (len_n == 16'd0) begin
                        state_d = TAIL;
                    end else if ({16'd0, len_n} > DEPTH_U) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    word_d = {word_q[15:0], byte_in};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {word_q, byte_in};
                        addr_d  = BASE_U + {16'd0, idx_q};
                        idx_d   = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) begin
                            state_d = TAIL;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    err_d   = (byte_in != csum_q);
                    state_d = DONE;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            bcnt_q  <= 2'd0;
            word_q  <= 24'd0;
            addr_q  <= BASE_U;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign done      = (state_q == DONE);
    assign error     = err_q;
    // Core is released only after a clean load.
    assign core_hold = !(done && !err_q);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: random and directed boot frames.
// Expected writes come from a byte-stream parser model; a monitor checks strobes.
module tb_instr_loader;

    localparam int DEPTH = 4;
    localparam int BASE  = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        core_hold;
    logic        done;
    logic        error;

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got addr %h data %h expected none",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.a);
                check("wr_data", mem_wdata, e.d);
            end
        end
    end

    // Reference: parse the byte stream and derive writes and final error flag.
    function automatic bit model();
        int  i = 0;
        int  n;
        logic [7:0] x = 8'd0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        n = {frame[i+1], frame[i+2]};
        i += 3;
        if (n > DEPTH) return 1'b1;
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.a = BASE + w;
            e.d = {frame[i], frame[i+1], frame[i+2], frame[i+3]};
            x = x ^ frame[i] ^ frame[i+1] ^ frame[i+2] ^ frame[i+3];
            exp_q.push_back(e);
            i += 4;
        end
`ifdef LOADER_CHECKSUM_EN
        return frame[i] != x;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clock);
            byte_valid = 1'b0;
        end
        @(negedge clock);
        byte_in    = b;
        byte_valid = 1'b1;
    endtask

    task automatic check_reset_vals();
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_hold", core_hold, 1);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clock);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        if (chk) check_reset_vals();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        if (chk) check("rst_ready", byte_ready, 1);
    endtask

    task automatic run_frame(input string tag, input int gap);
        bit eerr;
        do_reset(1'b0);
        eerr = model();
        foreach (frame[k]) send(frame[k], gap < 0 ? int'($urandom_range(0, 2)) : gap);
        @(negedge clock);
        byte_valid = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, error, 32'(eerr));
        check({tag, "_hold"}, core_hold, 32'(eerr));
        check({tag, "_ready"}, byte_ready, 0);
        repeat (3) @(negedge clock);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_we_idle"}, mem_we, 0);
        check({tag, "_done_sticky"}, done, 1);
        exp_q.delete();
    endtask

    task automatic build(input int npre, input int n, input bit bad);
        logic [7:0] x = 8'd0;
        logic [7:0] b;
        frame.delete();
        for (int p = 0; p < npre; p++) begin
            b = 8'($urandom);
            frame.push_back(b == 8'hA5 ? 8'h5A : b);
        end
        frame.push_back(8'hA5);
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        if (n <= DEPTH) begin
            for (int k = 0; k < 4 * n; k++) begin
                b = 8'($urandom);
                x ^= b;
                frame.push_back(b);
            end
`ifdef LOADER_CHECKSUM_EN
            frame.push_back(bad ? x ^ 8'(1 + $urandom_range(0, 254)) : x);
`else
            if (bad) x = 8'd0;
`endif
        end
    endtask

    initial begin
        do_reset(1'b1);

        frame = '{8'h11, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'h22);
`endif
        run_frame("single", 0);

        frame = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'h00);
`endif
        run_frame("toggle", 1);

        frame = '{8'hA5, 8'h00, 8'h05};
        run_frame("overflow", 0);

        frame = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'h00);
`endif
        run_frame("empty", 0);

`ifdef LOADER_CHECKSUM_EN
        frame = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame("cs_bad", 0);
        frame = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        run_frame("cs_good", 0);
`endif

        // Abort mid-word: nothing may be written for the partial word.
        do_reset(1'b0);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        foreach (frame[k]) send(frame[k], 0);
        @(negedge clock);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals();
        repeat (4) @(negedge clock);
        reset = 1'b0;
        build(1, 2, 1'b0);
        run_frame("after_abort", 0);

        for (int t = 0; t < 40; t++) begin
            build($urandom_range(0, 3), $urandom_range(0, DEPTH + 2),
                  $urandom_range(0, 3) == 0);
            run_frame("rand", -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter: DEPTH, 1024, number of 32-bit words in instruction memory (max loadable word count).
REQ-002 SHALL have parameter: BASE_ADDR, 0, word address of first written word.
REQ-003 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: byte_in  input  8  incoming boot-stream byte.
REQ-006 SHALL have port: byte_valid  input  1  byte_in holds a valid byte.
REQ-007 SHALL have port: byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port: mem_addr  output  32  instruction-memory word address (PC units).
REQ-009 SHALL have port: mem_wdata  output  32  instruction word to write.
REQ-010 SHALL have port: mem_we  output  1  one-cycle write strobe.
REQ-011 SHALL have port: core_hold  output  1  high = core PC/fetch held off.
REQ-012 SHALL have port: done  output  1  load finished (sticky).
REQ-013 SHALL have port: error  output  1  load failed (sticky).

Function
REQ-014 SHALL accept a byte only on a rising edge where byte_valid && byte_ready.
REQ-015 SHALL parse frame: sync 0xA5, count N as 16-bit big-endian (hi, lo), then N words of 4 bytes each, big-endian (first byte = bits 31:24).
REQ-016 SHALL use FSM states IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE; reset state IDLE.
REQ-017 IDLE: byte 0xA5 -> LEN_HI; any other accepted byte discarded, stay IDLE.
REQ-018 LEN_HI -> LEN_LO -> DATA on each accepted byte; after LEN_LO: N=0 -> CHK (CHECKSUM_EN) or DONE; N>DEPTH -> DONE with error=1.
REQ-019 DATA: assemble bytes in a 2-bit byte counter; on the 4th accepted byte, mem_we SHALL pulse high for exactly the next cycle with mem_wdata = assembled word, mem_addr = BASE_ADDR + word index (index 0..N-1).
REQ-020 Word index SHALL increment after each write; after write of word N-1, go to CHK (CHECKSUM_EN) or DONE.
REQ-021 byte_ready SHALL be 1 in IDLE, LEN_HI, LEN_LO, DATA, CHK; 0 in DONE; no back-pressure during writes (full throughput, one byte per cycle).
REQ-022 mem_we SHALL be 0 in every cycle other than the strobe in REQ-019; mem_addr/mem_wdata hold last value otherwise.
REQ-023 done SHALL rise on entering DONE and stay 1 until reset; DONE is terminal.
REQ-024 core_hold SHALL be 1 in all states except DONE with error=0.
REQ-025 byte_valid low mid-word SHALL stall assembly without losing partial bytes.

Reset
REQ-026 reset high SHALL immediately force IDLE, byte/word counters 0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, error=0, core_hold=1, byte_ready=1 (after release).
REQ-027 reset mid-frame SHALL abandon the frame; words already written remain in memory; no strobe after reset assertion.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN: defined -> one trailing byte in CHK, required equal to XOR of all 4N data bytes (0x00 when N=0); mismatch -> DONE with error=1, match -> DONE error=0.
REQ-029 LOADER_CHECKSUM_EN undefined -> no CHK state reachable; last word goes straight to DONE; error only from N>DEPTH.

Verification
REQ-030 Bytes 0x11,0xA5,0x00,0x01,0xDE,0xAD,0xBE,0xEF (+0x22 if checksum) -> one mem_we, addr 0, wdata 0xDEADBEEF; done=1, error=0, core_hold=0.
REQ-031 Frame N=3, words 1,2,3, byte_valid toggled every other cycle -> writes at addr 0,1,2 with data 1,2,3, exactly 3 strobes.
REQ-032 DEPTH=4, count 0x0005 -> no strobe, done=1, error=1, core_hold=1, byte_ready=0.
REQ-033 LOADER_CHECKSUM_EN, N=1 word 0x01020304, checksum 0x05 -> error=1; checksum 0x04 -> error=0.
REQ-034 Assert reset after 2nd data byte of word 1 -> outputs at reset values, no strobe; subsequent full frame loads from addr 0 correctly.
REQ-035 Frame N=0 -> done=1 within 1 cycle of count low byte (no checksum) or after checksum 0x00, no strobe.
